// File: rtl/clk_step_ctrl.sv
// rtl/clk_step_ctrl.sv - CPU clock-enable controller with run, halt and single-step modes
module clk_step_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic        I_CLK,
    input  logic        rst_n,
    input  logic        slow_clk,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        halt_in,
    output logic        cpu_ce,
    output logic [1:0]  mode,
    output logic [31:0] ce_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [23:0] DEB_LAST = 24'(DEB_CYCLES - 1);

    logic [1:0]  slow_sync;
    logic [1:0]  btn_sync;
    logic [1:0]  run_sync;
    logic [1:0]  sync_vld;
    logic        slow_s;
    logic        btn_s;
    logic        run_s;
    logic        slow_q;
    logic        slow_armed;
    logic        tick;
    logic [23:0] deb_cnt;
    logic        deb_lvl;
    logic        step_req;
    state_t      state;
    state_t      state_nxt;
    logic        ce_nxt;

    assign slow_s = slow_sync[1];
    assign btn_s  = btn_sync[1];
    assign run_s  = run_sync[1];

    // Two-flop synchronizers; sync_vld marks when slow_s holds a real sample rather than reset fill
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            slow_sync <= '0;
            btn_sync  <= '0;
            run_sync  <= '0;
            sync_vld  <= '0;
        end else begin
            slow_sync <= {slow_sync[0], slow_clk};
            btn_sync  <= {btn_sync[0], btn_step};
            run_sync  <= {run_sync[0], sw_run};
            sync_vld  <= {sync_vld[0], 1'b1};
        end
    end

    // Rising-edge detect; a rise only counts after slow_clk has genuinely been seen low since reset
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            slow_q     <= 1'b0;
            slow_armed <= 1'b0;
        end else begin
            slow_q     <= slow_s;
            slow_armed <= slow_armed | (sync_vld[1] & ~slow_s);
        end
    end

    assign tick = slow_armed & slow_s & ~slow_q;

    // Debounce: level flips after DEB_CYCLES consecutive differing samples; rising flip raises step_req
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt  <= '0;
            deb_lvl  <= 1'b0;
            step_req <= 1'b0;
        end else begin
            step_req <= 1'b0;
            if (btn_s == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl  <= btn_s;
                deb_cnt  <= '0;
                step_req <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + 24'd1;
            end
        end
    end

    // State register, registered clock-enable pulse and pulse counter
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HALT;
            cpu_ce   <= 1'b0;
            ce_count <= '0;
        end else begin
            state  <= state_nxt;
            cpu_ce <= ce_nxt;
            if (ce_nxt) begin
                ce_count <= ce_count + 32'd1;
            end
        end
    end

    // Next state and pulse decision, both taken from the pre-change state
    always_comb begin
        state_nxt = state;
        ce_nxt    = 1'b0;
        case (state)
            ST_HALT: begin
                if (halt_in) begin
                    state_nxt = ST_HALT;
                end else if (run_s) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                ce_nxt = tick & ~halt_in;
                if (halt_in || !run_s) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_STEP: begin
                ce_nxt = tick & ~halt_in;
                if (halt_in || tick) begin
                    state_nxt = ST_HALT;
                end
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    assign mode = state;

endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 1000000, the number of consecutive stable I_CLK cycles needed to accept a button level change (legal range 2..2^24).
REQ-002 I_CLK  input  1  system clock; all state is clocked on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 slow_clk  input  1  divided square wave from the clock divider; treated as asynchronous.
REQ-005 btn_step  input  1  raw single-step push button, active-high, bouncy.
REQ-006 sw_run  input  1  raw run/halt switch; 1 means run.
REQ-007 halt_in  input  1  CPU halt request (e.g. break); active-high.
REQ-008 cpu_ce  output  1  CPU clock-enable pulse, registered, one I_CLK cycle wide.
REQ-009 mode  output  2  FSM state: 00 HALT, 01 RUN, 10 STEP.
REQ-010 ce_count  output  32  count of cpu_ce pulses issued.

Function
REQ-011 slow_clk, btn_step and sw_run SHALL each pass through a 2-flop synchronizer before use.
REQ-012 tick SHALL be high for exactly one cycle when the synchronized slow_clk is 1 and its previous-cycle value is 0.
REQ-013 The debouncer SHALL track the synchronized btn_step against a registered debounced level, using a 24-bit counter:
- counter clears whenever the inputs are equal;
- counter increments while they differ;
- the debounced level flips when the counter reaches DEB_CYCLES-1 while still differing, and the counter clears.
REQ-014 step_req SHALL be a one-cycle internal pulse on each 0->1 transition of the debounced level; 1->0 transitions produce nothing.
REQ-015 HALT transitions, in priority order:
- halt_in=1 -> stay HALT;
- else synchronized sw_run=1 -> RUN;
- else step_req -> STEP;
- else stay HALT.
REQ-016 RUN transitions: halt_in=1 or synchronized sw_run=0 -> HALT; else stay RUN.
REQ-017 STEP transitions: halt_in=1 -> HALT with no pulse; else tick -> HALT; else stay STEP.
REQ-018 cpu_ce SHALL be registered as 1 on the next edge exactly when either condition holds with halt_in=0:
- state RUN and tick;
- state STEP and tick.
REQ-019 Latency: cpu_ce SHALL go high on the 3rd I_CLK rising edge after a slow_clk rise that meets setup, and SHALL stay high for exactly 1 cycle.
REQ-020 halt_in=1 SHALL suppress any cpu_ce that would be registered on that edge; it has no effect on a pulse already registered.
REQ-021 A step_req arriving in RUN or STEP SHALL be discarded; requests are not queued.
REQ-022 ce_count SHALL increment by 1 on each edge where cpu_ce is registered 1, wrapping from 0xFFFFFFFF to 0.
REQ-023 A tick and a state change in the same cycle SHALL follow the pre-change state, per REQ-018.
REQ-024 mode SHALL reflect the registered FSM state with no combinational path from inputs.

Reset
REQ-025 When rst_n=0, all flops SHALL clear immediately, independent of I_CLK:
- synchronizers, edge-detect register, debounce counter and level;
- FSM to HALT;
- cpu_ce=0, ce_count=0, mode=00.
REQ-026 When rst_n deasserts, operation SHALL resume on the next I_CLK edge.
REQ-027 If slow_clk is already 1 at reset release, no tick SHALL be generated until slow_clk has gone low and then risen again.
REQ-028 Asserting rst_n mid-STEP or mid-debounce SHALL abandon the operation with no pulse.

Verification (DEB_CYCLES=4)
REQ-029 Scenario: sw_run=1, slow_clk period 20 I_CLK cycles for 100 cycles -> mode=01; 5 cpu_ce pulses, each 1 cycle wide, each 3 edges after a slow_clk rise; ce_count=5.
REQ-030 Scenario: HALT, btn_step bounces 1-0-1 at 1-cycle spacing then holds 1 -> exactly one step_req; STEP; one cpu_ce on the next tick; back to HALT; ce_count=1.
REQ-031 Scenario: btn_step high for 3 cycles then low -> no step_req; mode stays 00; no cpu_ce.
REQ-032 Scenario: RUN, halt_in=1 on the cycle where tick is high -> no cpu_ce; mode=00 next cycle; ce_count unchanged.
REQ-033 Scenario: ce_count forced near wrap (preload via 2^32-1 pulses in a fast-sim variant, or a bench force to 0xFFFFFFFF), one pulse -> ce_count=0.
REQ-034 Scenario: rst_n low for 1 ns mid-STEP, between clock edges -> outputs clear immediately; mode=00; no cpu_ce after release until a new step_req and tick.
